// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that takes one word at a time from several producers and
// feeds it MSB byte first to a shared UART TX core, pacing each byte write.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int BIT_WIDTH  = 32,
  parameter int GAP_CYCLES = 16,
  parameter int SKIP_ZERO  = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*BIT_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         uart_busy,
  output logic [7:0]                   uart_dat_i,
  output logic                         uart_wr_i,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         active,
  output logic [1:0]                   o_dbg_state
);

  localparam int BYTES = BIT_WIDTH / 8;
  localparam int GW    = $clog2(NUM_REQ);
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [BIT_WIDTH-1:0]   r_shift;
  logic [BCW-1:0]         r_byte_cnt;
  logic [CW-1:0]          r_gap;
  logic [GW-1:0]          r_last_grant;
  logic [GW-1:0]          r_grant_id;

  logic                   w_found;
  logic [GW-1:0]          w_winner;
  logic [NUM_REQ-1:0]     w_onehot;
  logic [BIT_WIDTH-1:0]   w_word;
  logic                   w_take;
  logic                   w_zero_skip;

  // Rotating priority: indices above the last grant first, then wrap to 0.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req_valid[i] && (GW'(i) > r_last_grant)) begin
        w_found  = 1'b1;
        w_winner = GW'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req_valid[i] && (GW'(i) <= r_last_grant)) begin
        w_found  = 1'b1;
        w_winner = GW'(i);
      end
    end
  end

  // Handshake: a word moves on a cycle where req_valid[i] and req_ready[i] are
  // both high; ready is offered only in IDLE, to at most one requester, and
  // never while reset is asserted.
  always_comb begin
    w_onehot           = '0;
    w_onehot[w_winner] = 1'b1;
  end

  assign req_ready   = (r_state == S_IDLE && w_found && !rst) ? w_onehot : '0;
  assign w_take      = |(req_valid & req_ready);
  assign w_word      = req_data[int'(w_winner)*BIT_WIDTH +: BIT_WIDTH];
  assign w_zero_skip = (SKIP_ZERO != 0) && (w_word == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    uart_wr_i = 1'b0;
    case (r_state)
      S_IDLE: if (w_take && !w_zero_skip) w_next = S_SEND;
      S_SEND: begin
        if (!uart_busy) begin
          uart_wr_i = 1'b1;
          w_next    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_gap == '0) w_next = (r_byte_cnt == '0) ? S_IDLE : S_SEND;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift      <= '0;
      r_byte_cnt   <= '0;
      r_gap        <= '0;
      r_last_grant <= GW'(NUM_REQ - 1);
      r_grant_id   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_shift      <= w_word;
            r_byte_cnt   <= BCW'(BYTES - 1);
            r_grant_id   <= w_winner;
            r_last_grant <= w_winner;
          end
        end
        S_SEND: begin
          if (!uart_busy) r_gap <= CW'(GAP_CYCLES - 1);
        end
        S_HOLD: begin
          // The UART's busy flag is ignored here; the holdoff covers its rise latency.
          if (r_gap == '0) begin
            if (r_byte_cnt != '0) begin
              r_shift    <= r_shift << 8;
              r_byte_cnt <= r_byte_cnt - BCW'(1);
            end
          end else begin
            r_gap <= r_gap - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign uart_dat_i  = r_shift[BIT_WIDTH-1 -: 8];
  assign grant_id    = r_grant_id;
  assign active      = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

endmodule
